// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard: producer classes,
// default latencies and the hard-wired zero register.
package id_hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_RSVD = 2'd3
    } prod_class_e;

    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_MUL_LAT  = 3;
    localparam int ZERO_REG     = 0;

    // Cycles a producer's result stays invisible to a dependent sitting in ID.
    function automatic int lat_of(input prod_class_e cls, input int load_lat, input int mul_lat);
        case (cls)
            CLS_LOAD: return load_lat;
            CLS_MUL:  return mul_lat;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_fwd_mux.sv
// Priority forwarding mux: the youngest stage (lowest index) writing the
// requested register wins, otherwise the register-file value passes through.
module id_hazard_scoreboard_fwd_mux
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FWD_STAGES = 2
) (
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [DATA_W-1:0]            i_rf_data,
    input  logic [FWD_STAGES-1:0]        i_fwd_we,
    input  logic [FWD_STAGES*ADDR_W-1:0] i_fwd_addr,
    input  logic [FWD_STAGES*DATA_W-1:0] i_fwd_data,
    output logic [DATA_W-1:0]            o_data
);

    always_comb begin
        // NOTE: o_data gets a default before any branch so no path leaves it
        // unassigned; without it a combinational block infers a latch.
        o_data = i_rf_data;
        if (i_addr != ADDR_W'(ZERO_REG)) begin
            // Walk oldest to youngest so the lowest matching index overrides.
            for (int i = FWD_STAGES - 1; i >= 0; i--) begin
                if (i_fwd_we[i] && (i_fwd_addr[i*ADDR_W +: ADDR_W] == i_addr)) begin
                    o_data = i_fwd_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register latency countdowns for RAW/WAW
// interlocks, operand forwarding and the LL/SC link bit.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = DEF_LOAD_LAT,
    parameter int MUL_LAT    = DEF_MUL_LAT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [ADDR_W-1:0]            id_rs_addr,
    input  logic [ADDR_W-1:0]            id_rt_addr,
    input  logic                         id_uses_rs,
    input  logic                         id_uses_rt,
    input  logic                         id_we,
    input  logic [ADDR_W-1:0]            id_wr_addr,
    input  logic [1:0]                   id_class,
    input  logic                         id_is_ll,
    input  logic                         id_is_sc,
    input  logic                         id_flush,
    input  logic                         llbit_clr,
    input  logic [DATA_W-1:0]            rs_data_rf,
    input  logic [DATA_W-1:0]            rt_data_rf,
    input  logic [FWD_STAGES-1:0]        fwd_we,
    input  logic [FWD_STAGES*ADDR_W-1:0] fwd_addr,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
    output logic                         stall,
    output logic                         issue,
    output logic [DATA_W-1:0]            rs_data,
    output logic [DATA_W-1:0]            rt_data,
    output logic                         atomic_id,
    output logic                         mem_sc_mask_id
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int MAX_LAT  = (MUL_LAT > LOAD_LAT) ? MUL_LAT : LOAD_LAT;
    localparam int CNT_W    = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] r_cnt [NUM_REGS];
    logic             r_link;

    logic [CNT_W-1:0] w_lat_id;
    logic             w_rs_busy;
    logic             w_rt_busy;
    logic             w_waw;
    logic             w_stall;
    logic             w_issue;
    logic             w_wr_track;

    assign w_lat_id   = CNT_W'(lat_of(prod_class_e'(id_class), LOAD_LAT, MUL_LAT));
    assign w_wr_track = id_we && (id_wr_addr != ADDR_W'(ZERO_REG));

    assign w_rs_busy = id_uses_rs && (id_rs_addr != ADDR_W'(ZERO_REG)) && (r_cnt[id_rs_addr] != '0);
    assign w_rt_busy = id_uses_rt && (id_rt_addr != ADDR_W'(ZERO_REG)) && (r_cnt[id_rt_addr] != '0);
    // An older long producer still outstanding must not retire after us.
    assign w_waw     = w_wr_track && (r_cnt[id_wr_addr] > w_lat_id);

    assign w_stall = id_valid && (w_rs_busy || w_rt_busy || w_waw);
    assign w_issue = id_valid && !w_stall && !id_flush;

    assign stall          = w_stall;
    assign issue          = w_issue;
    assign atomic_id      = r_link;
    assign mem_sc_mask_id = id_is_sc && !r_link;

    always_ff @(posedge clk) begin
        // NOTE: the countdown array is state the interlock depends on, so every
        // entry is cleared on reset rather than left as an unreset memory.
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_issue && w_wr_track && (id_wr_addr == ADDR_W'(r))) begin
                    r_cnt[r] <= w_lat_id;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_link <= 1'b0;
        end else if (llbit_clr) begin
            r_link <= 1'b0;
        end else if (w_issue && id_is_ll) begin
            r_link <= 1'b1;
        end else if (w_issue && id_is_sc) begin
            r_link <= 1'b0;
        end
    end

    id_hazard_scoreboard_fwd_mux #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd_rs (
        .i_addr     (id_rs_addr),
        .i_rf_data  (rs_data_rf),
        .i_fwd_we   (fwd_we),
        .i_fwd_addr (fwd_addr),
        .i_fwd_data (fwd_data),
        .o_data     (rs_data)
    );

    id_hazard_scoreboard_fwd_mux #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FWD_STAGES (FWD_STAGES)
    ) u_fwd_rt (
        .i_addr     (id_rt_addr),
        .i_rf_data  (rt_data_rf),
        .i_fwd_we   (fwd_we),
        .i_fwd_addr (fwd_addr),
        .i_fwd_data (fwd_data),
        .o_data     (rt_data)
    );

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Parametrised successor to the combinational decode-stage hazard logic of the MIPS core.
- Tracks in-flight register writes with per-register latency countdowns, so multi-cycle producers are interlocked correctly. Producers include loads and the new multi-cycle MUL.
- Selects forwarded operands from a configurable number of downstream stages.
- Owns the LL/SC link bit. Sits beside decode; decode supplies instruction fields and consumes stall, forwarded data and SC-mask.

Parameters:
- DATA_W, 32, operand width
- ADDR_W, 5, register address width (NUM_REGS = 2**ADDR_W)
- FWD_STAGES, 2, number of forwarding sources (index 0 = youngest, EX)
- LOAD_LAT, 1, cycles a load result is unavailable to a dependent in ID
- MUL_LAT, 3, cycles a MUL result is unavailable to a dependent in ID

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  instruction in ID is valid
- id_rs_addr  in  ADDR_W  source rs
- id_rt_addr  in  ADDR_W  source rt
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_we  in  1  instruction writes a register
- id_wr_addr  in  ADDR_W  destination
- id_class  in  2  producer class: 0 ALU, 1 LOAD, 2 MUL, 3 reserved (treated as ALU)
- id_is_ll  in  1  load-linked
- id_is_sc  in  1  store-conditional
- id_flush  in  1  squash the ID instruction (no issue)
- llbit_clr  in  1  external link invalidate (exception/ERET)
- rs_data_rf  in  DATA_W  register-file rs
- rt_data_rf  in  DATA_W  register-file rt
- fwd_we  in  FWD_STAGES  stage holds a valid register write
- fwd_addr  in  FWD_STAGES*ADDR_W  stage destinations
- fwd_data  in  FWD_STAGES*DATA_W  stage results
- stall  out  1  hold ID/IF this cycle
- issue  out  1  id_valid & ~stall & ~id_flush
- rs_data  out  DATA_W  forwarded rs
- rt_data  out  DATA_W  forwarded rt
- atomic_id  out  1  link bit
- mem_sc_mask_id  out  1  SC in ID must not store (link bit clear)

Behaviour:
- Reset (rst_n low at posedge): all counters 0, link bit 0. Combinational outputs follow from that state: stall 0 unless inputs demand it; atomic_id 0.
- Scoreboard state: cnt[r], width clog2(MUL_LAT+1), for r = 1..NUM_REGS-1. Register 0 is never tracked, stalled on or forwarded.
- Each cycle, every nonzero cnt decrements by 1.
- On issue with id_we and id_wr_addr != 0, cnt[id_wr_addr] is loaded with lat(class) instead: ALU 0, LOAD LOAD_LAT, MUL MUL_LAT. The load takes priority over the decrement for that entry.
- RAW stall: (id_uses_rs & rs != 0 & cnt[rs] != 0) or the same condition for rt.
- WAW stall: id_we & id_wr_addr != 0 & cnt[id_wr_addr] > lat(id_class). This prevents a younger, short producer from being overwritten by an older MUL.
- stall = id_valid & (RAW | WAW). A stalled or flushed instruction changes no state; counters keep decrementing.
- Forwarding (combinational):
  - rs_data = fwd_data[i] for the lowest i with fwd_we[i] & fwd_addr[i] == rs & rs != 0.
  - Otherwise rs_data = rs_data_rf. rt is identical.
  - Forwarding is unconditional on stall; decode ignores it while stalled.
- Link bit (next state):
  - llbit_clr has the highest priority and clears the bit.
  - Otherwise issue & id_is_ll sets it.
  - Otherwise issue & id_is_sc clears it.
- mem_sc_mask_id = id_is_sc & ~atomic_id, computed from the current register value (pre-update).
- Simultaneous LL issue with llbit_clr: the bit ends cleared.
- Reset mid-MUL: counters zeroed; the next instruction issues without stall.
- Latency: stall and forward are same-cycle combinational; scoreboard and link updates are visible the next cycle.

Decomposition:
- Shared package/defines file holds producer-class encodings (CLS_ALU, CLS_LOAD, CLS_MUL), the lat() mapping constants, and the ZERO register address.
- One natural sub-module, fwd_mux: a parametrised priority comparator/mux over FWD_STAGES, instantiated once for rs and once for rt.

Test Plan:
- MUL $3 issued at cycle t, then ADDU $4,$3,$5 waiting in ID -> stall high cycles t+1..t+3, issue at t+4; rs_data taken from fwd_data[stage holding $3].
- LW $2 then dependent BEQ $2,$0 -> exactly 1 stall cycle with LOAD_LAT=1; no stall when rs=$0.
- MUL $6 then ADDU $6 -> WAW stall until cnt[6] <= 0, i.e. 3 cycles; ADDU then MUL $6 -> no stall.
- Both fwd stages write $7 (0xAAAA_AAAA at index 0, 0x5555_5555 at index 1) -> rs_data = 0xAAAA_AAAA; only index 1 valid -> 0x5555_5555; neither -> rs_data_rf.
- LL, SC -> mem_sc_mask_id 0, atomic_id 0 afterwards; SC again -> mask 1; LL with llbit_clr in the same cycle -> atomic_id 0.
- rst_n low for 1 cycle during a MUL countdown -> all counters 0, dependent instruction issues immediately, atomic_id 0.
